// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared state encoding and widths for the truth table sweeper
package sweep_pkg;

   localparam int SETTLE_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } sweep_state_t;

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - loadable down-counter timing the per-vector settle interval
module settle_timer
   import sweep_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic [SETTLE_W-1:0] load_val,
   input  logic                dec,
   output logic                zero
);

   logic [SETTLE_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sweeps all input vectors of a circuit and captures its truth table
// Optional reference compare enabled by defining SWEEP_CHECK_EN.
module truth_table_sweeper
   import sweep_pkg::*;
#(
   parameter int N_IN   = 3,
   parameter int SETTLE = 1
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic [N_IN-1:0]      vec,
   input  logic                 f_in,
   output logic                 busy,
   output logic                 done,
   output logic [2**N_IN-1:0]   tt
`ifdef SWEEP_CHECK_EN
   ,
   input  logic [2**N_IN-1:0]   expected,
   output logic                 mismatch,
   output logic [N_IN:0]        err_count
`endif
);

   localparam int                  NV     = 2**N_IN;
   localparam logic [N_IN-1:0]     VMAX   = N_IN'(NV - 1);
   localparam logic [SETTLE_W-1:0] RELOAD = SETTLE_W'(SETTLE - 1);

   sweep_state_t state, next_state;
   logic         tmr_load, tmr_dec, tmr_zero;
   logic         accept, last_vec;

   settle_timer u_settle (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (RELOAD),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   assign accept   = (state == IDLE) && start;
   assign last_vec = (vec == VMAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      tmr_load   = 1'b0;
      tmr_dec    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = HOLD;
               tmr_load   = 1'b1;
            end
         end
         HOLD: begin
            if (tmr_zero) next_state = SAMPLE;
            else          tmr_dec    = 1'b1;
         end
         SAMPLE: begin
            if (last_vec) begin
               next_state = DONE;
            end else begin
               next_state = HOLD;
               tmr_load   = 1'b1;
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // vec returns to 0 on the final sample so DONE and IDLE both present 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec <= '0;
         tt  <= '0;
      end else if (accept) begin
         vec <= '0;
         tt  <= '0;
      end else if (state == SAMPLE) begin
         tt[vec] <= f_in;
         vec     <= last_vec ? '0 : vec + 1'b1;
      end
   end

   assign busy = (state == HOLD) || (state == SAMPLE);
   assign done = (state == DONE);

`ifdef SWEEP_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mismatch  <= 1'b0;
         err_count <= '0;
      end else if (accept) begin
         mismatch  <= 1'b0;
         err_count <= '0;
      end else if ((state == SAMPLE) && (f_in != expected[vec])) begin
         mismatch <= 1'b1;
         if (err_count != (N_IN+1)'(NV)) err_count <= err_count + 1'b1;
      end
   end
`endif

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Synthesizable stimulus/capture stage that sits directly upstream of a small combinational circuit under test. It drives the circuit's inputs through every input combination, waits a programmable settle time per vector, samples the circuit's single output, and assembles a complete truth table. This replaces free-running simulation counters with a start/busy/done-controlled sweep that can also run on hardware.

## Interface
Parameters:
- N_IN, default 3: number of circuit inputs swept; the table has 2^N_IN entries.
- SETTLE, default 1: hold cycles per vector before sampling; legal range 1–255.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a sweep; sampled only in IDLE.
- vec  output  N_IN  input vector driven to the circuit; vec[N_IN-1] maps to input a (MSB), vec[0] maps to input c (LSB).
- f_in  input  1  circuit output being captured.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the table is complete.
- tt  output  2^N_IN  captured truth table; tt[k] = f_in observed with vec==k.
- expected  input  2^N_IN  reference table (present only with SWEEP_CHECK_EN).
- mismatch  output  1  sticky compare-failure flag (SWEEP_CHECK_EN only).
- err_count  output  N_IN+1  number of failing entries (SWEEP_CHECK_EN only).

## Operation
- States: IDLE, HOLD, SAMPLE, DONE.
- IDLE: busy=0 and vec=0. When start=1 at an edge, clear tt (and mismatch/err_count), load the settle counter with SETTLE-1, and go to HOLD with vec=0.
- HOLD: decrement the settle counter. At 0, go to SAMPLE.
- SAMPLE, one cycle: write tt[vec] <= f_in. If vec == 2^N_IN-1, go to DONE. Otherwise increment vec, reload the settle counter, and go to HOLD.
- DONE, one cycle: done=1, busy=0, vec=0. Then go to IDLE.
- tt holds its value until the next accepted start.
- start asserted while busy or in DONE: ignored; no queuing.
- start held high continuously: a new sweep begins on the edge after DONE (back-to-back sweeps).
- vec width is exactly N_IN. The terminal compare prevents wrap-around; vec never wraps mid-sweep.
- Reset asserted mid-sweep: all outputs return to reset values immediately, independent of clk. No partial table is retained.

## Timing
- Reset values: vec=0, busy=0, done=0, tt=0, mismatch=0, err_count=0; state=IDLE.
- Each vector is driven for exactly SETTLE+1 cycles: SETTLE cycles in HOLD plus 1 cycle in SAMPLE. f_in is captured at the edge ending the SAMPLE cycle.
- Let the start-accept edge be cycle 0. Vector k is driven during cycles 1+k(SETTLE+1) through (k+1)(SETTLE+1).
- done is high in cycle 2^N_IN·(SETTLE+1)+1. With defaults, this is cycle 17.
- busy is high in cycles 1 through 2^N_IN·(SETTLE+1).
- f_in must be a combinational function of vec settling within SETTLE cycles.

## Configuration
- SWEEP_CHECK_EN defined: expected, mismatch, and err_count ports exist.
  - In SAMPLE, if f_in != expected[vec], set mismatch and increment err_count. err_count saturates at 2^N_IN.
  - Both are cleared on start acceptance and valid once done pulses.
  - expected must be stable from start until done.
- SWEEP_CHECK_EN undefined: those ports and their logic are absent; capture-only behaviour is unchanged.

## Structure
- Package sweep_pkg holds:
  - the state enum (IDLE, HOLD, SAMPLE, DONE);
  - localparam SETTLE_W = 8 for the settle counter width.
- Sub-module settle_timer: a loadable down-counter with load, load value, and zero flag.
- The FSM, vector counter, and table register live in the top module.

## Test plan
- Reset then idle: rst_n low 3 cycles, then start=0 for 20 cycles -> vec=0, busy=0, done=0, tt=8'h00 throughout.
- Default sweep with f_in = (a&b)|c, start pulsed at cycle 0 -> done high only in cycle 17, busy high in cycles 1–16, tt=8'hEA, vec stepping 0..7 every 2 cycles.
- SETTLE=3, f_in = a^b^c -> done in cycle 33, tt=8'h96; vec=5 driven in cycles 21–24.
- Mid-sweep reset: rst_n low at cycle 9, then a fresh start -> outputs at reset values while low; new sweep yields the correct 8'hEA with no residue.
- Start ignored while busy, then back-to-back: extra start pulses in cycles 4–10 have no effect; start held high continuously -> second sweep accepted at the edge after DONE, with done pulses at cycles 17 and 35.
- SWEEP_CHECK_EN, expected=8'hEA, f_in=(a&b)|c with index 3 forced wrong -> mismatch=1, err_count=1 at done; with a correct circuit -> mismatch=0, err_count=0.
